// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-client round-robin front end for the single-ported line memory
// Optional response-address checking is enabled by defining MEM_ARB_RESP_CHECK_EN.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c0_req,
    input  logic              c0_we,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [LINE_W-1:0] c0_wdata,
    output logic              c0_ready,
    output logic [LINE_W-1:0] c0_rdata,
    input  logic              c1_req,
    input  logic              c1_we,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [LINE_W-1:0] c1_wdata,
    output logic              c1_ready,
    output logic [LINE_W-1:0] c1_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_resp_addr,
    output logic              busy,
    output logic              resp_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t state, state_nxt;
    logic   last_grant;
    logic   grant;
    logic   sel;
    logic   issue_en;
    logic   accept;
    logic   mismatch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (c0_req || c1_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (accept) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        // On a tie the port not granted last wins; a lone requester always wins.
        sel      = (c0_req && c1_req) ? ~last_grant : c1_req;
        issue_en = (state == IDLE) && (c0_req || c1_req);
        busy     = (state != IDLE);
`ifdef MEM_ARB_RESP_CHECK_EN
        accept   = (state == WAIT) && mem_ready && (mem_resp_addr == mem_addr);
        mismatch = (state == WAIT) && mem_ready && (mem_resp_addr != mem_addr);
`else
        accept   = (state == WAIT) && mem_ready;
        mismatch = 1'b0;
`endif
    end

`ifndef MEM_ARB_RESP_CHECK_EN
    logic unused_resp_addr;
    assign unused_resp_addr = ^{mem_resp_addr, mismatch};
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            grant      <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            c0_ready   <= 1'b0;
            c1_ready   <= 1'b0;
            c0_rdata   <= '0;
            c1_rdata   <= '0;
        end else begin
            mem_req  <= issue_en;
            c0_ready <= accept && !grant;
            c1_ready <= accept && grant;
            if (issue_en) begin
                grant      <= sel;
                last_grant <= sel;
                mem_we     <= sel ? c1_we : c0_we;
                mem_addr   <= {(sel ? c1_addr[ADDR_W-1:4] : c0_addr[ADDR_W-1:4]), 4'b0000};
                mem_wdata  <= sel ? c1_wdata : c0_wdata;
            end
            if (accept && !mem_we) begin
                if (grant) c1_rdata <= mem_rdata;
                else       c0_rdata <= mem_rdata;
            end
        end
    end

`ifdef MEM_ARB_RESP_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_err <= 1'b0;
        end else if (mismatch) begin
            resp_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         c0_req, c0_we, c1_req, c1_we;
    logic [31:0]  c0_addr, c1_addr;
    logic [127:0] c0_wdata, c1_wdata;
    logic         c0_ready, c1_ready;
    logic [127:0] c0_rdata, c1_rdata;
    logic         mem_req, mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic [31:0]  mem_resp_addr;
    logic         busy, resp_err;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] LINE_A = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] LINE_5 = {16{8'hA5}};
    localparam logic [127:0] LINE_B = 128'hDEAD_BEEF_0000_0000_CAFE_F00D_1234_5678;
    localparam logic [127:0] LINE_C = 128'h0F0F_0F0F_1E1E_1E1E_2D2D_2D2D_3C3C_3C3C;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .LINE_W(128)) dut (
        .clk(clk), .rst(rst),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c0_ready(c0_ready), .c0_rdata(c0_rdata),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_ready(c1_ready), .c1_rdata(c1_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_resp_addr(mem_resp_addr),
        .busy(busy), .resp_err(resp_err)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output int cyc);
        cyc = 0;
        while (mem_req !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("issue_timeout", mem_req, 1'b1);
    endtask

    // Moves from ISSUE into WAIT, idles lat cycles, then returns one matching response.
    task automatic respond(input int lat, input logic [127:0] d);
        tick();
        chk("single_req_pulse", mem_req, 1'b0);
        repeat (lat) tick();
        mem_ready     = 1'b1;
        mem_rdata     = d;
        mem_resp_addr = mem_addr;
        tick();
        mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        c0_req = 0; c0_we = 0; c0_addr = 0; c0_wdata = 0;
        c1_req = 0; c1_we = 0; c1_addr = 0; c1_wdata = 0;
        mem_rdata = 0; mem_ready = 0; mem_resp_addr = 0;
        do_reset();

        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 128'h0);
        chk("rst_ready", {c0_ready, c1_ready}, 2'b00);
        chk("rst_rdata", c0_rdata | c1_rdata, 128'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_resp_err", resp_err, 1'b0);

        // single read, unaligned address
        c0_req = 1; c0_we = 0; c0_addr = 32'h0000_0013;
        wait_req(cyc);
        chk("read_issue_lat", cyc, 1);
        chk("read_addr", mem_addr, 32'h0000_0010);
        chk("read_we", mem_we, 1'b0);
        chk("read_busy", busy, 1'b1);
        respond(4, LINE_A);
        chk("read_c0_ready", c0_ready, 1'b1);
        chk("read_c1_ready", c1_ready, 1'b0);
        chk("read_c0_rdata", c0_rdata, LINE_A);
        c0_req = 0;
        tick();
        chk("read_ready_pulse", c0_ready, 1'b0);
        chk("read_idle", busy, 1'b0);
        chk("read_rdata_held", c0_rdata, LINE_A);

        // stray response while idle
        mem_ready = 1; mem_rdata = LINE_C;
        tick();
        mem_ready = 0;
        chk("stray_ready", {c0_ready, c1_ready, busy}, 3'b000);
        chk("stray_rdata", c0_rdata, LINE_A);

        // write from port 1
        c1_req = 1; c1_we = 1; c1_addr = 32'h20; c1_wdata = LINE_5;
        wait_req(cyc);
        chk("write_addr", mem_addr, 32'h20);
        chk("write_we", mem_we, 1'b1);
        chk("write_wdata", mem_wdata, LINE_5);
        respond(2, LINE_B);
        chk("write_c1_ready", c1_ready, 1'b1);
        chk("write_c0_ready", c0_ready, 1'b0);
        chk("write_c1_rdata", c1_rdata, 128'h0);
        c1_req = 0; c1_we = 0;
        tick();

        // tie after reset: 0, then 1, then again 0, then 1
        do_reset();
        c0_addr = 32'h100; c1_addr = 32'h200; c1_wdata = 0;
        c0_req = 1; c1_req = 1;
        for (int r = 0; r < 2; r++) begin
            wait_req(cyc);
            chk("tie_first_addr", mem_addr, 32'h100);
            respond(1, LINE_B);
            chk("tie_first_ready", {c0_ready, c1_ready}, 2'b10);
            c0_req = 0;
            wait_req(cyc);
            chk("tie_second_lat", cyc, 2);
            chk("tie_second_addr", mem_addr, 32'h200);
            respond(1, LINE_C);
            chk("tie_second_ready", {c0_ready, c1_ready}, 2'b01);
            chk("tie_c1_rdata", c1_rdata, LINE_C);
            c0_req = 1;
        end
        c0_req = 0; c1_req = 0;
        tick();

        // back-to-back: port 0 holds req with a new address
        c0_addr = 32'h10; c0_req = 1;
        wait_req(cyc);
        respond(0, LINE_A);
        chk("b2b_ready1", c0_ready, 1'b1);
        c0_addr = 32'h30;
        tick();
        chk("b2b_gap_req", mem_req, 1'b0);
        tick();
        chk("b2b_req_w3", mem_req, 1'b1);
        chk("b2b_addr", mem_addr, 32'h30);
        respond(1, LINE_C);
        chk("b2b_ready2", c0_ready, 1'b1);
        chk("b2b_rdata2", c0_rdata, LINE_C);
        c0_req = 0;
        tick();

`ifdef MEM_ARB_RESP_CHECK_EN
        c0_addr = 32'h10; c0_req = 1;
        wait_req(cyc);
        tick();
        mem_ready = 1; mem_resp_addr = 32'h40; mem_rdata = LINE_B;
        tick();
        mem_ready = 0;
        chk("chk_no_ready", c0_ready, 1'b0);
        chk("chk_err", resp_err, 1'b1);
        chk("chk_busy", busy, 1'b1);
        mem_ready = 1; mem_resp_addr = 32'h10; mem_rdata = LINE_A;
        tick();
        mem_ready = 0;
        chk("chk_ready", c0_ready, 1'b1);
        chk("chk_rdata", c0_rdata, LINE_A);
        chk("chk_err_sticky", resp_err, 1'b1);
        c0_req = 0;
        tick();
`endif

        // reset while waiting, then a late response from the abandoned transaction
        c1_req = 1; c1_we = 0; c1_addr = 32'h50;
        wait_req(cyc);
        tick();
        chk("rstw_busy_pre", busy, 1'b1);
        rst = 1;
        #1;
        chk("rstw_async_addr", mem_addr, 32'h0);
        chk("rstw_async_busy", busy, 1'b0);
        c1_req = 0;
        tick();
        rst = 0;
        mem_ready = 1; mem_resp_addr = 32'h50; mem_rdata = LINE_B;
        tick();
        mem_ready = 0;
        chk("rstw_no_ready", {c0_ready, c1_ready}, 2'b00);
        chk("rstw_outputs", {mem_req, mem_we, busy, resp_err}, 4'b0000);
        chk("rstw_rdata", c0_rdata | c1_rdata, 128'h0);
        tick();
        chk("rstw_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Requester-side front end for the single-ported line memory. It arbitrates between two line clients (port 0: instruction cache refill, port 1: data cache refill/writeback) and issues one transaction at a time on the memory request/ready protocol. It pulses `mem_req` for one cycle and waits for the matching `mem_ready` pulse. It then returns read data or a write acknowledge to the granted client with a one-cycle `cN_ready` pulse.

## Interface
- `ADDR_W`, 32, address width of clients and memory.
- `LINE_W`, 128, line data width.
- `clk` in 1: single clock; every register samples on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `c0_req`, `c1_req` in 1 each: client requests; level signals, held until the matching `cN_ready`.
- `c0_we`, `c1_we` in 1 each: write (1) or read (0); stable while `cN_req` is high.
- `c0_addr`, `c1_addr` in ADDR_W each: request address.
- `c0_wdata`, `c1_wdata` in LINE_W each: write line.
- `c0_ready`, `c1_ready` out 1 each: one-cycle completion pulse.
- `c0_rdata`, `c1_rdata` out LINE_W each: read line; valid while `cN_ready`=1 and held afterwards.
- `mem_req` out 1: one-cycle request pulse to memory.
- `mem_we` out 1, `mem_addr` out ADDR_W, `mem_wdata` out LINE_W: transaction fields, registered.
- `mem_rdata` in LINE_W, `mem_ready` in 1, `mem_resp_addr` in ADDR_W: memory response.
- `busy` out 1: high in any state other than IDLE.
- `resp_err` out 1: sticky response-address mismatch flag (see Configuration).

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - If any `cN_req`=1, select the grant (see arbitration) and register `mem_we`, `mem_addr` and `mem_wdata` from that client.
  - `mem_addr[3:0]` is forced to 0 (line-aligned).
  - `mem_req`<=1, go to ISSUE.
- **ISSUE:** `mem_req` is high for exactly this cycle. `mem_req`<=0, go to WAIT.
- **WAIT:**
  - Hold `mem_we`, `mem_addr` and `mem_wdata` stable.
  - On an accepted `mem_ready`, register `cG_rdata`<=`mem_rdata` for reads only (a write leaves `cG_rdata` unchanged) and set `cG_ready`<=1. Go to RESP.
- **RESP:** `cG_ready` is high for this cycle only. Go to IDLE.
- **Client handshake:** the client must drop `cN_req` on the edge that ends its RESP cycle. A request still high in the following IDLE cycle is treated as a new request.
- **Arbitration:** round-robin over two ports.
  - The last-grant pointer updates on each IDLE->ISSUE transition.
  - When both ports request, the port not granted last wins. A single requester always wins.
- **Outstanding transactions:** at most one. `mem_req` is never raised while a transaction is outstanding.
- **Stray responses:** `mem_ready` in IDLE, ISSUE or RESP is ignored; no client pulse and no state change.
- **Non-granted client:** its request stays pending, with no effect on the current transaction.

## Timing
- **Reset values:**
  - All outputs 0: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `c0_ready`, `c1_ready`, `c0_rdata`, `c1_rdata`, `busy`, `resp_err`.
  - FSM in IDLE.
  - Last-grant pointer = port 1, so port 0 wins the first tie.
- **Request-to-issue:** a request seen in IDLE at cycle T gives `mem_req`=1 at T+1.
- **Completion:** an accepted `mem_ready` at cycle W gives `cG_ready`=1 at W+1 and IDLE at W+2.
- **Earliest next issue:** `mem_req` for the next transaction at W+3. This gives the memory at least two idle cycles between transactions.
- **Memory latency:** not assumed; WAIT lasts indefinitely.
- **Reset mid-transaction:**
  - FSM returns to IDLE and all outputs clear immediately.
  - A `mem_ready` arriving later from the abandoned transaction is ignored.
  - `resp_err` is not set by it.

## Configuration
- Macro: `MEM_ARB_RESP_CHECK_EN`.
- **Defined:** `mem_ready` in WAIT is accepted only if `mem_resp_addr` equals `mem_addr`.
  - On mismatch the pulse is dropped, the FSM stays in WAIT and `resp_err`<=1.
  - `resp_err` is sticky until reset.
- **Undefined:** any `mem_ready` in WAIT is accepted; `mem_resp_addr` is unused and `resp_err` is tied to 0.

## Test plan
- **Single read:** `c0_req`=1, `c0_addr`=0x0000_0013, memory returns line 0x1111…8888 after 5 cycles.
  - Expect a one-cycle `mem_req` with `mem_addr`=0x0000_0010 and `mem_we`=0.
  - Expect `c0_ready` one cycle after `mem_ready`, with `c0_rdata`=0x1111_2222_3333_4444_5555_6666_7777_8888.
- **Write:** `c1_req`=1, `c1_we`=1, `c1_addr`=0x20, `c1_wdata`=0xA5…A5.
  - Expect `mem_we`=1 and `mem_wdata`=0xA5…A5.
  - Expect `c1_ready` pulse; `c1_rdata` unchanged (0).
- **Tie after reset:** both ports request in the same cycle.
  - Port 0 is served first, then port 1.
  - Both request again: port 0 is served after port 1 (alternation), and exactly one `mem_req` pulse per transaction.
- **Back-to-back:** client keeps `req` high for one cycle after `ready` with a new address 0x30.
  - A second transaction for 0x30 issues exactly 3 cycles after the first `mem_ready`.
- **Address check:** with `MEM_ARB_RESP_CHECK_EN`, inject `mem_ready` with `mem_resp_addr`=0x40 while waiting on 0x10.
  - No `c0_ready`, `resp_err`=1.
  - A later matching `mem_ready` completes normally with `resp_err` still 1.
- **Reset in WAIT:** assert `rst` while in WAIT, then deliver `mem_ready` after release.
  - All outputs 0, no `cN_ready` pulse, `resp_err`=0.
